// File: rtl/instruction_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instruction_fetch_pkg
// Shared definitions for the instruction fetch unit and its fetch queue:
//   - address / data widths and the size of one instruction in bytes
//   - FSM state encoding for the fetch controller
//   - the queue entry type {pc, instr}
//   - word_align(): clears the byte offset of an address
// -----------------------------------------------------------------------------
package instruction_fetch_pkg;

    localparam int ADDR_WIDTH  = 32;
    localparam int DATA_WIDTH  = 32;
    localparam int INSTR_BYTES = 4;

    // Fetch controller states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } fetch_entry_t;

    function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] addr);
        return {addr[ADDR_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// DEPTH-entry FIFO of fetched instructions with their addresses.
// Ports:
//   clk, reset   - clock, asynchronous active-low reset (empties the queue)
//   push         - write push_entry at the tail (ignored when full without pop)
//   push_entry   - {pc, instr} to store
//   pop          - drop the head entry (ignored when empty)
//   flush        - discard every entry; wins over push and pop
//   head         - current head entry (meaningless while empty)
//   full, empty  - occupancy flags
//   count        - number of valid entries, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_queue
    import instruction_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  fetch_entry_t           push_entry,
    input  logic                   pop,
    input  logic                   flush,
    output fetch_entry_t           head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    fetch_entry_t     storage [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full queue can still accept a push in the same cycle it pops.
    assign do_push = push && (!full || do_pop);
    assign head    = storage[rd_ptr];

    // Storage array is data-only; validity is tracked by count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            storage[wr_ptr] <= push_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Fetches instructions from instruction memory into a small queue, with at
// most one memory request outstanding. Branch/jump redirects flush the queue
// and drop any response still in flight.
// Ports:
//   clk, reset          - clock, asynchronous active-low reset
//   pc                  - current program counter (external PC register)
//   pc_enable, next_pc  - PC register load strobe and value
//   redirect_valid/_pc  - redirect request and target
//   imem_req/_addr      - memory read request and word-aligned address
//   imem_gnt            - request accepted this cycle
//   imem_rvalid/_rdata  - read response
//   instr_valid, instr, instr_pc - queue head towards decode
//   instr_ready         - decode accepts the head
// -----------------------------------------------------------------------------
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] pc,
    output logic                  pc_enable,
    output logic [ADDR_WIDTH-1:0] next_pc,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] QUEUE_SLOTS = CW'(DEPTH);

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic [ADDR_WIDTH-1:0] captured_pc;
    logic                  granted;
    logic                  q_push;
    logic                  q_full;
    logic                  q_empty;
    logic [CW-1:0]         q_count;
    fetch_entry_t          q_push_entry;
    fetch_entry_t          q_head;

    // The request stays up until granted because pc only moves on a grant or a
    // redirect; a redirect is the only thing that can withdraw it.
    assign imem_req  = (state == ST_REQ) && (q_count < QUEUE_SLOTS);
    assign imem_addr = imem_req ? word_align(pc) : '0;
    assign granted   = imem_req && imem_gnt;

    // Next-state, push and PC-load decisions. A redirect overrides both the
    // grant increment and the queue push; the reset term keeps the PC strobe
    // quiet while the block is held in reset.
    always_comb begin
        state_next = state;
        q_push     = 1'b0;
        pc_enable  = 1'b0;
        next_pc    = '0;

        case (state)
            ST_IDLE: state_next = ST_REQ;
            ST_REQ: begin
                if (granted) begin
                    state_next = redirect_valid ? ST_DRAIN : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    state_next = imem_rvalid ? ST_REQ : ST_DRAIN;
                end else if (imem_rvalid) begin
                    q_push     = !q_full;
                    state_next = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (imem_rvalid) begin
                    state_next = ST_REQ;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (redirect_valid) begin
            pc_enable = 1'b1;
            next_pc   = redirect_pc;
        end else if (granted) begin
            pc_enable = 1'b1;
            next_pc   = pc + ADDR_WIDTH'(INSTR_BYTES);
        end

        if (!reset) begin
            pc_enable = 1'b0;
            next_pc   = '0;
        end
    end

    // State register plus the address of the request in flight, which is
    // paired with its response when it is pushed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            captured_pc <= '0;
        end else begin
            state <= state_next;
            if (granted) begin
                captured_pc <= pc;
            end
        end
    end

    assign q_push_entry = '{pc: captured_pc, instr: imem_rdata};

    fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (q_push),
        .push_entry(q_push_entry),
        .pop       (instr_valid && instr_ready),
        .flush     (redirect_valid),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    // Head fields are forced to zero when nothing valid is presented so the
    // outputs are clean in reset and after the queue drains.
    assign instr_valid = !q_empty;
    assign instr       = instr_valid ? q_head.instr : '0;
    assign instr_pc    = instr_valid ? q_head.pc : '0;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
// Drives the fetch unit with a behavioural PC register, a single-request
// instruction memory with configurable latency, and a downstream consumer.
// The expected stream is kept as a queue of {pc, instr}: a response is
// delivered only if no redirect or reset happened between its grant and its
// arrival.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        pc_enable;
    logic [31:0] next_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    instruction_fetch #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc            (pc),
        .pc_enable     (pc_enable),
        .next_pc       (next_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } entry_t;

    entry_t      exp_q[$];
    logic [31:0] grant_log[$];
    logic [31:0] pop_log[$];
    logic [31:0] pop_ins_log[$];

    int n_compared   = 0;
    int n_mismatched = 0;

    bit          started;
    bit          outstanding;
    bit          killed;
    logic [31:0] out_pc;
    bit          mem_pending;
    int          mem_cnt;

    int gnt_pct, ready_pct, redir_pct, stray_pct, lat_min, lat_max;

    bit          cur_grant;
    bit          cur_pce;
    logic [31:0] cur_npc;

    task automatic configure(input int g, input int r, input int rd, input int s,
                             input int lmin, input int lmax);
        gnt_pct   = g;
        ready_pct = r;
        redir_pct = rd;
        stray_pct = s;
        lat_min   = lmin;
        lat_max   = lmax;
    endtask

    task automatic clear_logs();
        grant_log.delete();
        pop_log.delete();
        pop_ins_log.delete();
    endtask

    // First half of a cycle: drive inputs on the falling edge, then compare
    // outputs with what the reference expects for this cycle.
    task automatic cycle_begin(input bit force_redir, input logic [31:0] rpc);
        bit          exp_req;
        bit          exp_valid;
        logic [31:0] exp_addr;
        @(negedge clk);
        redirect_valid = force_redir || ($urandom_range(99, 0) < redir_pct);
        redirect_pc    = force_redir ? rpc : $urandom;
        imem_gnt       = ($urandom_range(99, 0) < gnt_pct);
        instr_ready    = ($urandom_range(99, 0) < ready_pct);
        imem_rdata     = $urandom;
        if (mem_pending && mem_cnt == 0)
            imem_rvalid = 1'b1;
        else if (!mem_pending && ($urandom_range(99, 0) < stray_pct))
            imem_rvalid = 1'b1;
        else
            imem_rvalid = 1'b0;
        #1;
        exp_req   = started && !outstanding && (exp_q.size() < DEPTH);
        cur_grant = exp_req && imem_gnt;
        cur_pce   = redirect_valid || cur_grant;
        cur_npc   = redirect_valid ? redirect_pc : pc + 32'd4;
        exp_valid = (exp_q.size() > 0);
        exp_addr  = {pc[31:2], 2'b00};

        n_compared++;
        if (imem_req !== exp_req) begin
            n_mismatched++;
            $display("[TB] FAIL imem_req @%0t: got %b expected %b", $time, imem_req, exp_req);
        end
        if (exp_req) begin
            n_compared++;
            if (imem_addr !== exp_addr) begin
                n_mismatched++;
                $display("[TB] FAIL imem_addr @%0t: got %h expected %h", $time, imem_addr, exp_addr);
            end
        end
        n_compared++;
        if (pc_enable !== cur_pce) begin
            n_mismatched++;
            $display("[TB] FAIL pc_enable @%0t: got %b expected %b", $time, pc_enable, cur_pce);
        end
        if (cur_pce) begin
            n_compared++;
            if (next_pc !== cur_npc) begin
                n_mismatched++;
                $display("[TB] FAIL next_pc @%0t: got %h expected %h", $time, next_pc, cur_npc);
            end
        end
        n_compared++;
        if (instr_valid !== exp_valid) begin
            n_mismatched++;
            $display("[TB] FAIL instr_valid @%0t: got %b expected %b", $time, instr_valid, exp_valid);
        end
        if (exp_valid) begin
            n_compared++;
            if (instr !== exp_q[0].ins || instr_pc !== exp_q[0].pc) begin
                n_mismatched++;
                $display("[TB] FAIL head @%0t: got %h/%h expected %h/%h", $time,
                         instr_pc, instr, exp_q[0].pc, exp_q[0].ins);
            end
        end
    endtask

    // Second half: after the rising edge, advance the reference, the memory
    // and the PC register.
    task automatic cycle_end();
        entry_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0 && instr_ready) begin
            pop_log.push_back(exp_q[0].pc);
            pop_ins_log.push_back(exp_q[0].ins);
            e = exp_q.pop_front();
        end
        if (imem_rvalid && outstanding) begin
            if (!killed && !redirect_valid) begin
                e.pc  = out_pc;
                e.ins = imem_rdata;
                exp_q.push_back(e);
            end
            outstanding = 1'b0;
        end
        if (cur_grant) begin
            outstanding = 1'b1;
            out_pc      = pc;
            killed      = redirect_valid;
            grant_log.push_back({pc[31:2], 2'b00});
        end
        if (redirect_valid) begin
            exp_q.delete();
            if (outstanding) killed = 1'b1;
        end
        started = 1'b1;

        if (imem_rvalid) mem_pending = 1'b0;
        else if (mem_pending && mem_cnt > 0) mem_cnt--;
        if (cur_grant) begin
            mem_pending = 1'b1;
            mem_cnt     = int'($urandom_range(lat_max, lat_min)) - 1;
        end

        if (cur_pce) pc = cur_npc;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            cycle_begin(1'b0, 32'h0);
            cycle_end();
        end
    endtask

    // Holds reset low for n cycles with busy inputs and checks every output is
    // zero; the memory keeps running so late responses can arrive afterwards.
    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset          = 1'b0;
            redirect_valid = 1'b1;
            redirect_pc    = $urandom;
            imem_gnt       = 1'b1;
            instr_ready    = 1'b1;
            imem_rdata     = $urandom;
            imem_rvalid    = mem_pending && (mem_cnt == 0);
            #1;
            n_compared++;
            if ({pc_enable, imem_req, instr_valid} !== 3'b000) begin
                n_mismatched++;
                $display("[TB] FAIL reset_strobes: got pc_enable=%b imem_req=%b instr_valid=%b expected 0",
                         pc_enable, imem_req, instr_valid);
            end
            n_compared++;
            if (next_pc !== 32'h0 || imem_addr !== 32'h0) begin
                n_mismatched++;
                $display("[TB] FAIL reset_addr: got next_pc=%h imem_addr=%h expected 0", next_pc, imem_addr);
            end
            n_compared++;
            if (instr !== 32'h0 || instr_pc !== 32'h0) begin
                n_mismatched++;
                $display("[TB] FAIL reset_head: got instr=%h instr_pc=%h expected 0", instr, instr_pc);
            end
            @(posedge clk);
            #1;
            if (imem_rvalid) mem_pending = 1'b0;
            else if (mem_pending && mem_cnt > 0) mem_cnt--;
        end
        reset = 1'b1;
        exp_q.delete();
        outstanding = 1'b0;
        killed      = 1'b0;
        started     = 1'b0;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        configure(100, 100, 0, 0, 1, 1);
        pc = 32'h1234_5678;
        do_reset(4);
    endtask

    task automatic test_sequential();
        $display("[TB] test_sequential");
        configure(100, 100, 0, 0, 1, 1);
        pc = 32'h0;
        do_reset(2);
        clear_logs();
        run_cycles(12);
        n_compared++;
        if (grant_log.size() < 3 || grant_log[0] !== 32'h0 || grant_log[1] !== 32'h4 || grant_log[2] !== 32'h8) begin
            n_mismatched++;
            $display("[TB] FAIL seq_addr: got %0d grants, first %h expected 0,4,8", grant_log.size(),
                     (grant_log.size() > 0) ? grant_log[0] : 32'hx);
        end
        n_compared++;
        if (pop_log.size() < 3 || pop_log[0] !== 32'h0 || pop_log[1] !== 32'h4 || pop_log[2] !== 32'h8) begin
            n_mismatched++;
            $display("[TB] FAIL seq_instr_pc: got %0d pops expected instr_pc 0,4,8", pop_log.size());
        end
    endtask

    task automatic test_backpressure();
        $display("[TB] test_backpressure");
        configure(100, 0, 0, 0, 1, 1);
        pc = 32'h0;
        do_reset(2);
        clear_logs();
        run_cycles(7);
        cycle_begin(1'b0, 32'h0);
        n_compared++;
        if (imem_req !== 1'b0 || pc_enable !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL full_hold: got imem_req=%b pc_enable=%b expected 0/0", imem_req, pc_enable);
        end
        n_compared++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
            n_mismatched++;
            $display("[TB] FAIL full_head: got valid=%b pc=%h expected 1/00000000", instr_valid, instr_pc);
        end
        cycle_end();
        n_compared++;
        if (grant_log.size() != 2) begin
            n_mismatched++;
            $display("[TB] FAIL full_count: got %0d queued expected 2", grant_log.size());
        end
        ready_pct = 100;
        run_cycles(12);
        n_compared++;
        if (grant_log.size() < 3 || grant_log[2] !== 32'h8) begin
            n_mismatched++;
            $display("[TB] FAIL resume_addr: got %0d grants expected third at 00000008", grant_log.size());
        end
        n_compared++;
        if (pop_log.size() < 3 || pop_log[0] !== 32'h0 || pop_log[1] !== 32'h4 || pop_log[2] !== 32'h8) begin
            n_mismatched++;
            $display("[TB] FAIL resume_order: got %0d pops expected 0,4,8 in order", pop_log.size());
        end
    endtask

    task automatic test_redirect_wait();
        $display("[TB] test_redirect_wait");
        configure(100, 100, 0, 0, 3, 3);
        pc = 32'h0;
        do_reset(2);
        clear_logs();
        run_cycles(2);
        cycle_begin(1'b1, 32'h100);
        n_compared++;
        if (pc_enable !== 1'b1 || next_pc !== 32'h100) begin
            n_mismatched++;
            $display("[TB] FAIL redirect_pc: got %b/%h expected 1/00000100", pc_enable, next_pc);
        end
        cycle_end();
        run_cycles(12);
        n_compared++;
        if (pop_log.size() < 1 || pop_log[0] !== 32'h100) begin
            n_mismatched++;
            $display("[TB] FAIL redirect_first: got %0d pops, first %h expected 00000100", pop_log.size(),
                     (pop_log.size() > 0) ? pop_log[0] : 32'hx);
        end
    endtask

    task automatic test_redirect_rvalid();
        logic [31:0] dropped;
        $display("[TB] test_redirect_rvalid");
        configure(100, 100, 0, 0, 2, 2);
        pc = 32'h40;
        do_reset(2);
        clear_logs();
        run_cycles(3);
        cycle_begin(1'b1, 32'h200);
        dropped = imem_rdata;
        cycle_end();
        run_cycles(12);
        n_compared++;
        if (pop_log.size() < 1 || pop_log[0] !== 32'h200) begin
            n_mismatched++;
            $display("[TB] FAIL coincide_restart: got %0d pops, first %h expected 00000200", pop_log.size(),
                     (pop_log.size() > 0) ? pop_log[0] : 32'hx);
        end
        foreach (pop_ins_log[i]) begin
            n_compared++;
            if (pop_ins_log[i] === dropped) begin
                n_mismatched++;
                $display("[TB] FAIL coincide_drop: got dropped data %h on instr, expected it discarded", dropped);
            end
        end
    endtask

    task automatic test_wrap();
        $display("[TB] test_wrap");
        configure(100, 100, 0, 0, 1, 1);
        pc = 32'hFFFF_FFFC;
        do_reset(2);
        clear_logs();
        run_cycles(1);
        cycle_begin(1'b0, 32'h0);
        n_compared++;
        if (pc_enable !== 1'b1 || next_pc !== 32'h0) begin
            n_mismatched++;
            $display("[TB] FAIL wrap_next_pc: got %b/%h expected 1/00000000", pc_enable, next_pc);
        end
        cycle_end();
        run_cycles(8);
        n_compared++;
        if (pop_log.size() < 2 || pop_log[0] !== 32'hFFFF_FFFC || pop_log[1] !== 32'h0) begin
            n_mismatched++;
            $display("[TB] FAIL wrap_order: got %0d pops expected fffffffc then 00000000", pop_log.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] stray;
        $display("[TB] test_reset_mid");
        configure(100, 100, 0, 0, 2, 2);
        pc = 32'h0;
        do_reset(2);
        run_cycles(2);
        clear_logs();
        do_reset(1);
        cycle_begin(1'b0, 32'h0);
        stray = imem_rdata;
        cycle_end();
        cycle_begin(1'b0, 32'h0);
        n_compared++;
        if (instr_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL stray_rvalid: got instr_valid=%b instr=%h expected 0", instr_valid, instr);
        end
        cycle_end();
        run_cycles(10);
        n_compared++;
        if (pop_log.size() < 1 || pop_log[0] !== 32'h4 || pop_ins_log[0] === stray) begin
            n_mismatched++;
            $display("[TB] FAIL reset_restart: got %0d pops, first %h expected 00000004", pop_log.size(),
                     (pop_log.size() > 0) ? pop_log[0] : 32'hx);
        end
    endtask

    task automatic test_random();
        $display("[TB] test_random");
        configure(60, 70, 8, 10, 1, 4);
        pc = $urandom & 32'hFFFF_FFFC;
        do_reset(2);
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(99, 0) < 1)
                do_reset(1 + int'($urandom_range(1, 0)));
            else
                run_cycles(1);
        end
    endtask

    initial begin
        reset          = 1'b0;
        pc             = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        instr_ready    = 1'b0;
        started        = 1'b0;
        outstanding    = 1'b0;
        killed         = 1'b0;
        out_pc         = 32'h0;
        mem_pending    = 1'b0;
        mem_cnt        = 0;
        cur_grant      = 1'b0;
        cur_pce        = 1'b0;
        cur_npc        = 32'h0;
        configure(0, 0, 0, 0, 1, 1);

        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_redirect_rvalid();
        test_wrap();
        test_reset_mid();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
